// File: rtl/vend_coin_sequencer.sv
// Coin front-end for the vending core: queues acceptor coins and replays them
// to the core as single-cycle coinx/coiny pulses with a fixed idle gap.
module vend_coin_sequencer #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       coin_x_in,
  input  logic                       coin_y_in,
  output logic                       coin_reject,
  output logic                       vend_coinx,
  output logic                       vend_coiny,
  input  logic                       vend_prod,
  input  logic                       vend_change,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       busy,
  output logic [CNT_W-1:0]           prod_cnt,
  output logic [CNT_W-1:0]           change_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // state | meaning
  // IDLE  | waiting for a queued coin; pops the head when enabled
  // ISSUE | vend_coinx/vend_coiny pulse is on the core interface
  // WAIT  | enforced all-low gap, gap_q counts down to 0
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             coin_reject_q, coin_reject_d;
  logic             vend_coinx_q, vend_coinx_d;
  logic             vend_coiny_q, vend_coiny_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] prod_cnt_q, prod_cnt_d;
  logic [CNT_W-1:0] change_cnt_q, change_cnt_d;

  logic full, empty, push, pop, head;

  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    vend_coinx_d  = 1'b0;
    vend_coiny_d  = 1'b0;
    pop           = 1'b0;
    head          = mem_q[rd_ptr_q];

    full  = (count_q == LW'(DEPTH));
    empty = (count_q == '0);
    push  = en & ~flush & (coin_x_in ^ coin_y_in) & ~full;
    coin_reject_d = en & ~flush & (coin_x_in | coin_y_in) &
                    ((coin_x_in & coin_y_in) | full);

    case (state_q)
      IDLE: begin
        if (en & ~empty & ~flush) begin
          pop          = 1'b1;
          vend_coinx_d = ~head;
          vend_coiny_d = head;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        gap_d   = GW'(GAP_CYCLES - 1);
      end
      WAIT: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = coin_y_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase

    // Flush wins over any push/pop decided above on the same edge.
    if (flush) begin
      state_d      = IDLE;
      gap_d        = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      vend_coinx_d = 1'b0;
      vend_coiny_d = 1'b0;
    end

    prod_cnt_d   = (vend_prod && prod_cnt_q != CNT_MAX) ? prod_cnt_q + CNT_W'(1) : prod_cnt_q;
    change_cnt_d = (vend_change && change_cnt_q != CNT_MAX) ? change_cnt_q + CNT_W'(1) : change_cnt_q;

    busy_d = (state_d != IDLE) | (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gap_q         <= '0;
      mem_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      coin_reject_q <= 1'b0;
      vend_coinx_q  <= 1'b0;
      vend_coiny_q  <= 1'b0;
      busy_q        <= 1'b0;
      prod_cnt_q    <= '0;
      change_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      coin_reject_q <= coin_reject_d;
      vend_coinx_q  <= vend_coinx_d;
      vend_coiny_q  <= vend_coiny_d;
      busy_q        <= busy_d;
      prod_cnt_q    <= prod_cnt_d;
      change_cnt_q  <= change_cnt_d;
    end
  end

  assign coin_reject = coin_reject_q;
  assign vend_coinx  = vend_coinx_q;
  assign vend_coiny  = vend_coiny_q;
  assign fifo_level  = count_q;
  assign busy        = busy_q;
  assign prod_cnt    = prod_cnt_q;
  assign change_cnt  = change_cnt_q;

endmodule

// File: tb/tb_vend_coin_sequencer.sv
// Bench for vend_coin_sequencer: directed scenarios plus random traffic, all
// checked against a timeline/queue reference model.
module tb_vend_coin_sequencer;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int CNT_W = 2;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, flush = 1'b0, cx = 1'b0, cy = 1'b0, vp = 1'b0, vc = 1'b0;
  logic coin_reject, vend_coinx, vend_coiny, busy;
  logic [LW-1:0]    fifo_level;
  logic [CNT_W-1:0] prod_cnt, change_cnt;

  vend_coin_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .coin_x_in(cx), .coin_y_in(cy), .coin_reject(coin_reject),
    .vend_coinx(vend_coinx), .vend_coiny(vend_coiny),
    .vend_prod(vp), .vend_change(vc), .fifo_level(fifo_level),
    .busy(busy), .prod_cnt(prod_cnt), .change_cnt(change_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: coin queue plus the edge index of the last issued coin.
  // A coin may be issued GAP+2 edges after the previous one; the sequencer is
  // back to idle GAP+1 edges after an issue.
  int mq[$];
  int last_pop = -100;
  int e = 0;
  int m_rej = 0, m_vx = 0, m_vy = 0, m_prod = 0, m_chg = 0;

  task automatic model_reset();
    mq.delete();
    last_pop = -100;
    m_rej = 0; m_vx = 0; m_vy = 0; m_prod = 0; m_chg = 0;
  endtask

  task automatic model_edge();
    bit full;
    int c;
    e++;
    if (flush) begin
      mq.delete();
      last_pop = -100;
      m_rej = 0; m_vx = 0; m_vy = 0;
    end else begin
      full  = (mq.size() == DEPTH);
      m_rej = (en && (cx || cy) && ((cx && cy) || full)) ? 1 : 0;
      m_vx = 0; m_vy = 0;
      if (en && mq.size() > 0 && e >= last_pop + GAP + 2) begin
        c = mq.pop_front();
        last_pop = e;
        m_vx = (c == 0) ? 1 : 0;
        m_vy = (c == 1) ? 1 : 0;
      end
      if (en && (cx ^ cy) && !full) mq.push_back(cy ? 1 : 0);
    end
    if (vp && m_prod < CMAX) m_prod++;
    if (vc && m_chg < CMAX) m_chg++;
  endtask

  task automatic check_all();
    int m_busy;
    m_busy = (mq.size() != 0 || e < last_pop + GAP + 1) ? 1 : 0;
    chk("coin_reject", coin_reject, m_rej);
    chk("vend_coinx", vend_coinx, m_vx);
    chk("vend_coiny", vend_coiny, m_vy);
    chk("fifo_level", fifo_level, mq.size());
    chk("busy", busy, m_busy);
    chk("prod_cnt", prod_cnt, m_prod);
    chk("change_cnt", change_cnt, m_chg);
    chk("vend_onehot", vend_coinx & vend_coiny, 0);
  endtask

  task automatic drive(input bit e_, input bit f_, input bit x_, input bit y_,
                       input bit p_, input bit c_);
    en = e_; flush = f_; cx = x_; cy = y_; vp = p_; vc = c_;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Called 1 time unit after an edge; asserts reset between clock edges.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2 check_all();
    #10 rst_n = 1'b1;

    // Single x coin
    drive(1, 0, 1, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0); step();
    chk("t1_vx_pulse", vend_coinx, 1);
    step(); step(); step();
    chk("t1_busy_done", busy, 0);

    // Burst y,x,y,x
    drive(1, 0, 0, 1, 0, 0); step();
    drive(1, 0, 1, 0, 0, 0); step();
    drive(1, 0, 0, 1, 0, 0); step();
    drive(1, 0, 1, 0, 0, 0); step();
    chk("t2_peak_level", fifo_level, 3);
    drive(1, 0, 0, 0, 0, 0);
    repeat (18) step();

    // Overflow: queue fills while the sequencer is busy, then a coin hits full
    repeat (5) begin drive(1, 0, 1, 0, 0, 0); step(); end
    chk("t3_full_level", fifo_level, DEPTH);
    step();
    chk("t3_reject", coin_reject, 1);
    drive(1, 0, 0, 0, 0, 0);
    repeat (20) step();
    chk("t3_drained", fifo_level, 0);

    // Illegal double coin
    drive(1, 0, 1, 1, 0, 0); step();
    chk("t4_reject", coin_reject, 1);
    chk("t4_level", fifo_level, 0);
    drive(1, 0, 0, 0, 0, 0); step();
    chk("t4_no_vend", {vend_coinx, vend_coiny}, 0);

    // Flush during WAIT with 3 queued
    drive(1, 0, 1, 0, 1, 0); step();
    drive(1, 0, 0, 1, 0, 1); step();
    drive(1, 0, 1, 0, 0, 0); step();
    drive(1, 0, 1, 0, 0, 0); step();
    chk("t5_pre_level", fifo_level, 3);
    drive(1, 1, 0, 0, 0, 0); step();
    chk("t5_level", fifo_level, 0);
    chk("t5_busy", busy, 0);
    chk("t5_prod_kept", prod_cnt, 1);
    drive(1, 0, 0, 0, 0, 0);
    repeat (4) step();

    // Counter saturation, then reset mid-WAIT
    do_reset();
    drive(1, 0, 0, 0, 1, 0); repeat (4) step();
    drive(1, 0, 0, 0, 1, 1); step();
    drive(1, 0, 0, 0, 0, 0); step();
    chk("t6_prod_sat", prod_cnt, 3);
    chk("t6_change", change_cnt, 1);
    drive(1, 0, 1, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0); step(); step(); step();
    do_reset();
    chk("t6_rst_out", {coin_reject, vend_coinx, vend_coiny, busy, fifo_level, prod_cnt, change_cnt}, 0);

    // Random traffic
    begin
      int en_pct = 90;
      for (int i = 0; i < 3000; i++) begin
        bit r_en, r_fl, r_x, r_y, r_p, r_c;
        int pick;
        if (i % 60 == 0) en_pct = (i % 120 == 0) ? 95 : 40;
        r_en = ($urandom_range(99) < en_pct);
        r_fl = ($urandom_range(99) < 3);
        pick = $urandom_range(99);
        r_x = (pick < 30) || (pick >= 95);
        r_y = (pick >= 30 && pick < 60) || (pick >= 95);
        r_p = !r_fl && ($urandom_range(99) < 10);
        r_c = !r_fl && ($urandom_range(99) < 10);
        drive(r_en, r_fl, r_x, r_y, r_p, r_c);
        step();
        if ($urandom_range(999) < 4) do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
